exp5_unidade_controle_rodadas: RTL and testbench

Moore control unit for the multi-round sequence-memory game. Generalises the single-pass play/compare controller: drives a play-address counter (E), a round counter (L) and the play register, so round k requires k correct plays. It adds a parametrised inactivity timeout on each play. Sits beside the datapath, which supplies the `igual`, `fim_rodada` and `fim_jogo` flags.

---
 rtl/exp5_unidade_controle_rodadas_pkg.sv | 24 ++
 rtl/exp5_unidade_controle_rodadas_contador_timeout.sv | 32 +++
 rtl/exp5_unidade_controle_rodadas.sv | 133 +++++++++++++
 tb/tb_exp5_unidade_controle_rodadas.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp5_unidade_controle_rodadas_pkg.sv
// State codes and helpers for the multi-round game control unit.
// Shared by the control unit, the datapath debug decoder and the bench.
package exp5_unidade_controle_rodadas_pkg;

  localparam logic [3:0] INICIAL        = 4'd0;
  localparam logic [3:0] INICIALIZA     = 4'd1;
  localparam logic [3:0] INICIA_RODADA  = 4'd2;
  localparam logic [3:0] ESPERA         = 4'd4;
  localparam logic [3:0] REGISTRA       = 4'd5;
  localparam logic [3:0] COMPARA        = 4'd6;
  localparam logic [3:0] PROXIMA_JOGADA = 4'd7;
  localparam logic [3:0] PROXIMA_RODADA = 4'd8;
  localparam logic [3:0] ESGOTADO       = 4'd13;
  localparam logic [3:0] ERRO           = 4'd14;
  localparam logic [3:0] ACERTO         = 4'd15;

  function automatic logic eh_terminal(
    input logic [3:0] e
  );
    return (e == ACERTO) || (e == ERRO) ||
           (e == ESGOTADO);
  endfunction

endpackage

// File: rtl/exp5_unidade_controle_rodadas_contador_timeout.sv
// Saturating inactivity counter for the espera state.
// Used only when TIMEOUT_EN is defined.
module contador_timeout #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TIMEOUT_W      = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [TIMEOUT_W-1:0] ULTIMO =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt;

  // holds at the last value instead of wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta && !fim) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fim = (cnt == ULTIMO);

endmodule

// File: rtl/exp5_unidade_controle_rodadas.sv
// Moore control unit for the multi-round sequence-memory game.
// Define TIMEOUT_EN to enable the per-play inactivity timeout.
module exp5_unidade_controle_rodadas
  import exp5_unidade_controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TIMEOUT_W      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_rodada,
  input  logic       fim_jogo,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  logic [3:0] estado;
  logic [3:0] prox;
  logic       expira;

`ifdef TIMEOUT_EN
  logic fim_to;

  contador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .zera (estado != ESPERA),
    .conta(estado == ESPERA),
    .fim  (fim_to)
  );

  assign expira = fim_to && (estado == ESPERA);
`else
  localparam int unused_cfg = TIMEOUT_CYCLES + TIMEOUT_W;
  assign expira = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox = INICIAL;
    unique case (estado)
      INICIAL:
        prox = iniciar ? INICIALIZA : INICIAL;
      INICIALIZA:
        prox = INICIA_RODADA;
      INICIA_RODADA:
        prox = ESPERA;
      // a play in the expiry cycle still counts
      ESPERA: begin
        if (jogada) begin
          prox = REGISTRA;
        end else if (expira) begin
          prox = ESGOTADO;
        end else begin
          prox = ESPERA;
        end
      end
      REGISTRA:
        prox = COMPARA;
      COMPARA: begin
        if (!igual) begin
          prox = ERRO;
        end else if (!fim_rodada) begin
          prox = PROXIMA_JOGADA;
        end else if (!fim_jogo) begin
          prox = PROXIMA_RODADA;
        end else begin
          prox = ACERTO;
        end
      end
      PROXIMA_JOGADA:
        prox = ESPERA;
      PROXIMA_RODADA:
        prox = INICIA_RODADA;
`ifdef TIMEOUT_EN
      ESGOTADO:
        prox = iniciar ? INICIALIZA : ESGOTADO;
`endif
      ERRO:
        prox = iniciar ? INICIALIZA : ERRO;
      ACERTO:
        prox = iniciar ? INICIALIZA : ACERTO;
      default:
        prox = INICIAL;
    endcase
  end

  assign zeraE = (estado == INICIAL) ||
                 (estado == INICIALIZA) ||
                 (estado == INICIA_RODADA);
  assign zeraL = (estado == INICIAL) ||
                 (estado == INICIALIZA);
  assign zeraR = zeraL;

  assign contaE    = (estado == PROXIMA_JOGADA);
  assign contaL    = (estado == PROXIMA_RODADA);
  assign registraR = (estado == REGISTRA);
  assign acertou   = (estado == ACERTO);
  assign errou     = (estado == ERRO);

`ifdef TIMEOUT_EN
  assign timeout = (estado == ESGOTADO);
  assign pronto  = eh_terminal(estado);
`else
  assign timeout = 1'b0;
  assign pronto  = acertou || errou;
`endif

  assign db_estado = estado;

endmodule

// File: tb/tb_exp5_unidade_controle_rodadas.sv
// Bench for exp5_unidade_controle_rodadas: game-level model,
// per-cycle output compare and directed scenarios.
module tb_exp5_unidade_controle_rodadas;
  import exp5_unidade_controle_rodadas_pkg::*;

  localparam int TC = 8;
  localparam int NR = 3;
`ifdef TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic jogada = 1'b0;
  logic igual = 1'b1;
  logic fim_rodada = 1'b0;
  logic fim_jogo = 1'b0;
  logic zeraE, contaE, zeraL, contaL;
  logic zeraR, registraR, acertou, errou;
  logic timeout, pronto;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ce = 0;
  int n_cl = 0;

  // game model: current state code, address E, round L, idle cycles
  int ms = 0;
  int m_E = 0;
  int m_L = 0;
  int m_wait = 0;
  int ns;

  // injected wrong play: round err_L, play err_E
  bit err_en = 1'b0;
  int err_L = 0;
  int err_E = 0;

  always #5 clock = ~clock;

  exp5_unidade_controle_rodadas #(
    .TIMEOUT_CYCLES(TC),
    .TIMEOUT_W     (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fim_rodada(fim_rodada),
    .fim_jogo  (fim_jogo),
    .zeraE     (zeraE),
    .contaE    (contaE),
    .zeraL     (zeraL),
    .contaL    (contaL),
    .zeraR     (zeraR),
    .registraR (registraR),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  // expected outputs per state:
  // {zeraE,contaE,zeraL,contaL,zeraR,registraR,acertou,errou,timeout,pronto}
  function automatic logic [9:0] exp_out(input int s);
    case (s)
      0, 1:    return 10'b1010100000;
      2:       return 10'b1000000000;
      5:       return 10'b0000010000;
      7:       return 10'b0100000000;
      8:       return 10'b0001000000;
      13:      return 10'b0000000011;
      14:      return 10'b0000000101;
      15:      return 10'b0000001001;
      default: return 10'b0000000000;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ms = 0;
      m_E = 0;
      m_L = 0;
      m_wait = 0;
    end else begin
      ns = ms;
      if (ms == 0) begin
        ns = iniciar ? 1 : 0;
      end else if (ms == 1) begin
        ns = 2;
      end else if (ms == 2) begin
        ns = 4;
      end else if (ms == 4) begin
        if (jogada) ns = 5;
        else if (TO_EN && m_wait == TC - 1) ns = 13;
      end else if (ms == 5) begin
        ns = 6;
      end else if (ms == 6) begin
        if (!igual) ns = 14;
        else if (m_E != m_L) ns = 7;
        else if (m_L != NR - 1) ns = 8;
        else ns = 15;
      end else if (ms == 7) begin
        ns = 4;
      end else if (ms == 8) begin
        ns = 2;
      end else if (iniciar) begin
        ns = 1;
      end
      if (ms <= 2) m_E = 0;
      if (ms <= 1) m_L = 0;
      if (ms == 7) m_E = m_E + 1;
      if (ms == 8) m_L = m_L + 1;
      m_wait = (ms == 4) ? m_wait + 1 : 0;
      ms = ns;
    end
  end

  task automatic chk(input string nm, input int got,
                     input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, got, want);
    end
  endtask

  // one cycle: compare outputs after the edge, drive datapath flags
  task automatic tick();
    @(posedge clock);
    #1;
    chk("cycle",
        {db_estado, zeraE, contaE, zeraL, contaL, zeraR,
         registraR, acertou, errou, timeout, pronto},
        {ms[3:0], exp_out(ms)});
    if (contaE) n_ce++;
    if (contaL) n_cl++;
    @(negedge clock);
    fim_rodada = (m_E == m_L);
    fim_jogo   = (m_L == NR - 1);
    igual      = !(err_en && m_L == err_L && m_E == err_E);
  endtask

  task automatic wait_state(input int s, input int lim);
    for (int i = 0; i < lim && ms != s; i++) tick();
    chk("reach", db_estado, s);
  endtask

  task automatic pulse_jogada();
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  int ce0, cl0, k;

  initial begin
    #2;
    chk("rst_estado", db_estado, 0);
    chk("rst_zeras", {zeraE, zeraL, zeraR}, 3'b111);
    chk("rst_outs",
        {contaE, contaL, registraR, acertou, errou,
         timeout, pronto}, 0);
    @(negedge clock);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_inicial", db_estado, 0);

    // full game, three rounds
    ce0 = n_ce;
    cl0 = n_cl;
    pulse_iniciar();
    chk("inicializa", db_estado, 1);
    repeat (6) begin
      wait_state(4, 60);
      pulse_jogada();
    end
    wait_state(15, 60);
    chk("acertou", {acertou, pronto}, 2'b11);
    chk("contaL_n", n_cl - cl0, 2);
    chk("contaE_n", n_ce - ce0, 3);

    // restart with iniciar held; wrong second play of round 2
    err_en = 1'b1;
    err_L = 1;
    err_E = 1;
    iniciar = 1'b1;
    repeat (3) tick();
    iniciar = 1'b0;
    repeat (2) begin
      wait_state(4, 60);
      pulse_jogada();
    end
    wait_state(4, 60);
    pulse_jogada();
    chk("err_reg", db_estado, 5);
    tick();
    chk("err_cmp", db_estado, 6);
    tick();
    chk("err_verdict", db_estado, 14);
    chk("errou", {errou, pronto}, 2'b11);
    pulse_jogada();
    tick();
    chk("jog_ignored", db_estado, 14);
    err_en = 1'b0;

`ifdef TIMEOUT_EN
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
    chk("to_entry", db_estado, 4);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick();
      if (db_estado == 13) k = i;
    end
    chk("to_latency", k, TC);
    chk("to_flags", {timeout, pronto}, 2'b11);
    pulse_iniciar();
    chk("to_restart", db_estado, 1);
    tick();
    tick();
    chk("late_entry", db_estado, 4);
    repeat (TC - 1) tick();
    pulse_jogada();
    chk("late_jogada", db_estado, 5);
    chk("late_no_to", timeout, 0);
`else
    pulse_iniciar();
    wait_state(4, 60);
    pulse_iniciar();
    chk("ini_ignored", db_estado, 4);
    repeat (10000) tick();
    chk("no_to_estado", db_estado, 4);
    chk("no_to_flag", timeout, 0);
`endif

    // asynchronous reset in compara
    wait_state(4, 60);
    pulse_jogada();
    tick();
    chk("pre_rst", db_estado, 6);
    reset = 1'b1;
    #1;
    chk("async_rst", db_estado, 0);
    chk("async_zeras", {zeraE, zeraL, zeraR}, 3'b111);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst", db_estado, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
